// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared FSM states, perf register offsets and defaults for the perf MMIO bridge
package perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [3:0]  PERF_RST = 4'h0;
    localparam logic [3:0]  PERF_EN  = 4'h4;
    localparam logic [3:0]  PERF_LO  = 4'h8;
    localparam logic [3:0]  PERF_HI  = 4'hC;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Only word-aligned offsets name a perf register.
    function automatic logic is_perf_reg(input logic [3:0] off);
        return (off == PERF_RST) || (off == PERF_EN) || (off == PERF_LO) || (off == PERF_HI);
    endfunction

endpackage

// File: rtl/perf_mmio_bridge.sv
// rtl/perf_mmio_bridge.sv - CPU MMIO window to perf command/response bridge with decode-error and timeout absorption
module perf_mmio_bridge
    import perf_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned TIMEOUT   = 256,
    parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [3:0]  cmd_addr_o,
    output logic        cmd_data_o,
    input  logic        prsp_valid_i,
    output logic        prsp_ready_o,
    input  logic [31:0] prsp_data_i
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);

    state_e        state_q, state_d;
    logic [3:0]    cmd_addr_q, cmd_addr_d;
    logic          cmd_data_q, cmd_data_d;
    logic          we_q, we_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic          drain_q, drain_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          hit;
    logic          unused_wdata;

    assign unused_wdata = ^req_wdata_i[31:1];
    assign hit = (req_addr_i[31:4] == BASE_ADDR[31:4]) && is_perf_reg(req_addr_i[3:0]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_addr_q <= '0;
            cmd_data_q <= 1'b0;
            we_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            drain_q    <= 1'b0;
            timer_q    <= '0;
        end else begin
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
            we_q       <= we_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            drain_q    <= drain_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        we_d       = we_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        drain_d    = drain_q;
        timer_d    = timer_q;
        unique case (state_q)
            ST_IDLE: begin
                // A perf response orphaned by a timeout must be swallowed before new work.
                if (drain_q) begin
                    if (prsp_valid_i) drain_d = 1'b0;
                end else if (req_valid_i) begin
                    we_d = req_we_i;
                    if (hit) begin
                        cmd_addr_d = req_addr_i[3:0];
                        cmd_data_d = req_we_i & req_wdata_i[0];
                        state_d    = ST_CMD;
                    end else begin
                        rsp_data_d = req_we_i ? 32'h0 : ERR_DATA;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_CMD: begin
                if (cmd_ready_i) begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
                if (prsp_valid_i) begin
                    rsp_data_d = we_q ? 32'h0 : prsp_data_i;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (timer_q == TIMER_LAST) begin
                    rsp_data_d = we_q ? 32'h0 : ERR_DATA;
                    rsp_err_d  = 1'b1;
                    drain_d    = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = (state_q == ST_IDLE) && !drain_q;
        cmd_valid_o  = (state_q == ST_CMD);
        prsp_ready_o = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && drain_q);
        rsp_valid_o  = (state_q == ST_RESP);
    end

    assign cmd_addr_o = cmd_addr_q;
    assign cmd_data_o = cmd_data_q;
    assign rsp_data_o = rsp_data_q;
    assign rsp_err_o  = rsp_err_q;

endmodule

// File: tb/tb_perf_mmio_bridge.sv
// tb/tb_perf_mmio_bridge.sv - scoreboard bench for perf_mmio_bridge with a behavioural perf peer
module tb_perf_mmio_bridge;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          TO   = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic        cmd_valid, cmd_ready, cmd_data;
    logic [3:0]  cmd_addr;
    logic        prsp_valid, prsp_ready;
    logic [31:0] prsp_data;

    perf_mmio_bridge #(.BASE_ADDR(BASE), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_addr_o(cmd_addr), .cmd_data_o(cmd_data),
        .prsp_valid_i(prsp_valid), .prsp_ready_o(prsp_ready), .prsp_data_i(prsp_data)
    );

    typedef struct { logic [31:0] data; logic err; bit hit; int lat; int acc; int rstall; } rsp_t;
    typedef struct { logic [3:0] addr; logic dat; int stall; int delay; logic [31:0] pdata; } cmd_t;

    rsp_t exp_q[$];
    cmd_t cmd_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cmd_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference decode: a perf register is any aligned word inside the 16-byte window.
    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'd16) && ((a % 4) == 0);
    endfunction

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int cstall, input int delay, input logic [31:0] pdata,
                         input int rstall, input bit want_rsp);
        rsp_t r;
        cmd_t c;
        bit   h;
        int   n;
        h = in_window(addr);
        req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            fail_now("req_accept");
            req_valid = 1'b0;
            return;
        end
        if (h) begin
            c.addr = addr[3:0]; c.dat = we & wdata[0];
            c.stall = cstall; c.delay = delay; c.pdata = pdata;
            cmd_q.push_back(c);
        end
        r.hit = h; r.rstall = rstall; r.acc = cyc + 1;
        if (!h) begin
            r.err = 1'b1; r.data = we ? 32'h0 : ERRD; r.lat = 0;
        end else if (delay >= TO) begin
            r.err = 1'b1; r.data = we ? 32'h0 : ERRD; r.lat = TO;
        end else begin
            r.err = 1'b0; r.data = we ? 32'h0 : pdata; r.lat = delay + 1;
        end
        if (want_rsp) exp_q.push_back(r);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 500 && !(exp_q.size() == 0 && cmd_q.size() == 0 && !rsp_valid && !prsp_valid && req_ready)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_now("wait_idle");
    endtask

    // Perf peer: accepts commands after a per-command stall, answers after a per-command delay.
    initial begin
        cmd_t c;
        logic [3:0] ha;
        logic hd;
        int n;
        cmd_ready = 1'b0; prsp_valid = 1'b0; prsp_data = 32'h0;
        forever begin
            @(negedge clk);
            if (rst || !cmd_valid) continue;
            check("cmd_expected", cmd_q.size() != 0, 1);
            if (cmd_q.size() == 0) begin
                c.addr = cmd_addr; c.dat = cmd_data; c.stall = 0; c.delay = 0; c.pdata = 32'h0;
            end else begin
                c = cmd_q.pop_front();
            end
            ha = cmd_addr; hd = cmd_data;
            for (int s = 0; s < c.stall; s++) begin
                @(negedge clk);
                check("cmd_valid_hold", cmd_valid, 1);
                check("cmd_payload_stable", {cmd_addr, cmd_data}, {ha, hd});
            end
            cmd_ready = 1'b1;
            check("cmd_addr", cmd_addr, c.addr);
            check("cmd_data", cmd_data, c.dat);
            @(negedge clk);
            cmd_ready = 1'b0;
            cmd_cyc = cyc;
            for (int k = 0; k < c.delay && !rst; k++) @(negedge clk);
            if (rst) continue;
            prsp_valid = 1'b1; prsp_data = c.pdata;
            n = 0;
            while (!prsp_ready && !rst && n < 300) begin
                if (c.delay >= TO) check("req_ready_before_drain", req_ready, 0);
                @(negedge clk);
                n++;
            end
            if (rst) begin
                prsp_valid = 1'b0;
                continue;
            end
            if (!prsp_ready) begin
                fail_now("prsp_accept");
                prsp_valid = 1'b0;
                continue;
            end
            if (c.delay >= TO) check("req_ready_at_drain", req_ready, 0);
            @(negedge clk);
            prsp_valid = 1'b0; prsp_data = 32'h0;
        end
    end

    // CPU response monitor: pops the scoreboard whenever the bridge presents a response.
    initial begin
        rsp_t r;
        logic [32:0] hold;
        int want_cyc;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !rsp_valid) continue;
            check("rsp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() == 0) begin
                rsp_ready = 1'b1;
                @(negedge clk);
                rsp_ready = 1'b0;
                continue;
            end
            r = exp_q.pop_front();
            want_cyc = r.hit ? cmd_cyc + r.lat : r.acc;
            check("rsp_latency", cyc, want_cyc);
            hold = {rsp_err, rsp_data};
            for (int s = 0; s < r.rstall; s++) begin
                @(negedge clk);
                check("rsp_valid_hold", rsp_valid, 1);
                check("rsp_payload_stable", {rsp_err, rsp_data}, hold);
            end
            rsp_ready = 1'b1;
            check("rsp_data", rsp_data, r.data);
            check("rsp_err", rsp_err, r.err);
            @(negedge clk);
            rsp_ready = 1'b0;
            check("rsp_cleared", {rsp_valid, rsp_err, rsp_data}, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int sel;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_outputs", {cmd_valid, rsp_valid, prsp_ready, rsp_err, cmd_data, cmd_addr}, 0);
        check("reset_rsp_data", rsp_data, 0);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b0, BASE + 32'h8, 32'h0, 0, 1, 32'h0000_1234, 0, 1'b1);
        issue(1'b1, BASE + 32'h4, 32'h1, 0, 0, 32'hFFFF_FFFF, 0, 1'b1);
        issue(1'b1, BASE + 32'h4, 32'h2, 0, 2, 32'h5555_AAAA, 1, 1'b1);
        issue(1'b0, BASE + 32'h10, 32'h0, 0, 0, 32'h0, 0, 1'b1);
        issue(1'b0, BASE + 32'h9, 32'h0, 0, 0, 32'h0, 0, 1'b1);
        issue(1'b1, BASE - 32'h4, 32'h1, 0, 0, 32'h0, 0, 1'b1);
        issue(1'b0, BASE + 32'h0, 32'h0, 1, 12, 32'h7777_0000, 0, 1'b1);
        issue(1'b0, BASE + 32'h8, 32'h0, 0, TO - 1, 32'h0BAD_CAFE, 0, 1'b1);
        issue(1'b1, BASE + 32'hC, 32'h3, 0, TO, 32'h0, 1, 1'b1);
        issue(1'b0, BASE + 32'hC, 32'h0, 5, 2, 32'h0000_ABCD, 3, 1'b1);
        wait_idle();

        issue(1'b0, BASE + 32'h0, 32'h0, 0, 50, 32'h0, 0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_req_ready", req_ready, 1);
        check("async_rst_outputs", {cmd_valid, rsp_valid, prsp_ready, rsp_err, cmd_data, cmd_addr}, 0);
        check("async_rst_rsp_data", rsp_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(1'b0, BASE + 32'hC, 32'h0, 0, 0, 32'h00C0_FFEE, 0, 1'b1);
        wait_idle();

        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sel = $urandom_range(0, 9);
            if (sel < 7)      a = BASE + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
            else if (sel < 8) a = BASE + {28'h0, 4'($urandom_range(0, 15)) | 4'h1};
            else if (sel < 9) a = BASE + 32'h10 + 32'($urandom_range(0, 255));
            else              a = $urandom;
            issue(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2),
                  $urandom_range(0, 9), $urandom, $urandom_range(0, 2), 1'b1);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
